// File: rtl/asymmetric_gather_fifo.sv
// Gather FIFO: accepts one element per push and delivers the N_OUT oldest
// elements as a single word per pop. The circular buffer may have any depth,
// including depths that are not a power of two.
module asymmetric_gather_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned N_OUT      = 4,
  localparam int unsigned USAGE_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               testmode_i,
  input  dtype               data_i,
  input  logic               push_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [USAGE_W-1:0] usage_o,
  output dtype [N_OUT-1:0]   data_o,
  input  logic               pop_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The sum is one bit wider than a pointer. Because N_OUT <= DEPTH, a single
  // conditional subtract of DEPTH is enough to wrap it back into range.
  localparam logic [PTR_W:0]   DEPTH_S = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   N_OUT_S = (PTR_W + 1)'(N_OUT);
  localparam logic [USAGE_W-1:0] DEPTH_U = USAGE_W'(DEPTH);
  localparam logic [USAGE_W-1:0] N_OUT_U = USAGE_W'(N_OUT);
  localparam logic [USAGE_W-1:0] ONE_U   = USAGE_W'(1);

  if (N_OUT < 1 || N_OUT > DEPTH) begin : g_param_check
    $error("asymmetric_gather_fifo: need DEPTH >= N_OUT >= 1");
  end

  typedef logic [PTR_W-1:0] ptr_t;

  dtype               mem [DEPTH];
  ptr_t               wr_ptr_q, rd_ptr_q;
  ptr_t               wr_ptr_d, rd_ptr_d;
  logic [USAGE_W-1:0] usage_q, usage_d;
  logic               push_acc, pop_acc;

  // testmode_i has no functional effect on this block.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Adds an offset to a pointer, wrapping at DEPTH. The offset is at most DEPTH.
  function automatic ptr_t wrap_add(input ptr_t base, input logic [PTR_W:0] inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= DEPTH_S) sum = sum - DEPTH_S;
    return sum[PTR_W-1:0];
  endfunction

  assign full_o   = (usage_q == DEPTH_U);
  assign empty_o  = (usage_q < N_OUT_U);
  assign usage_o  = usage_q;

  // A push while full is dropped even when a pop frees room in the same cycle.
  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;

  // Next-state computation for the pointers and the usage count. A flush takes
  // priority over any push or pop that arrives in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wrap_add(wr_ptr_q, (PTR_W + 1)'(1));
        usage_d  = usage_d + ONE_U;
      end
      if (pop_acc) begin
        rd_ptr_d = wrap_add(rd_ptr_q, N_OUT_S);
        usage_d  = usage_d - N_OUT_U;
      end
    end
  end

  // Pointer and usage registers. Reset clears them without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Element storage. It has no reset; the contents are only meaningful when
  // the usage count covers them.
  always_ff @(posedge clk_i) begin
    if (push_acc && !flush_i) mem[wr_ptr_q] <= data_i;
  end

  // Output lanes read the oldest N_OUT entries straight from storage.
  // Lane 0 holds the oldest entry.
  always_comb begin
    for (int k = 0; k < int'(N_OUT); k++) begin
      data_o[k] = mem[wrap_add(rd_ptr_q, (PTR_W + 1)'(k))];
    end
  end

endmodule
